// File: rtl/mem_addr_sel.sv
// Memory address selector: registers one of NCH data channel addresses, or runs
// an exception-vector fetch sequence. Optional stall port via MEM_ADDR_SEL_STALL_EN.
module mem_addr_sel #(
  parameter int WIDTH    = 32,
  parameter int NCH      = 4,
  parameter int VEC_BASE = 253,
  parameter int NVEC     = 3,
  parameter int MEM_LAT  = 1,
  localparam int SW      = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MEM_ADDR_SEL_STALL_EN
  input  logic                 stall,
`endif
  input  logic [SW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic                 vec_req,
  input  logic [1:0]           vec_cause,
  output logic [WIDTH-1:0]     addr_out,
  output logic                 addr_valid,
  output logic                 vec_busy,
  output logic                 vec_done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, VEC_ADDR, VEC_WAIT, VEC_DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_addr;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_stall;
  logic             w_sel_ok;
  logic             w_cause_ok;
  logic [WIDTH-1:0] w_ch;
  logic [WIDTH-1:0] w_vec_addr;

`ifdef MEM_ADDR_SEL_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // Channel mux and legality decode; an out-of-range sel selects nothing
  always_comb begin
    w_sel_ok   = (int'(sel) < NCH);
    w_cause_ok = (int'(vec_cause) < NVEC);
    w_vec_addr = WIDTH'(VEC_BASE) + WIDTH'(vec_cause);
    w_ch       = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ch = w_ch | ({WIDTH{int'(sel) == i}} & data_in[i*WIDTH +: WIDTH]);
    end
  end

  // Main FSM; a stall freezes every register, including pending pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (!w_stall) begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (vec_req && w_cause_ok) begin
            r_state <= VEC_ADDR;
            r_addr  <= w_vec_addr;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            if (w_sel_ok) begin
              r_addr  <= w_ch;
              r_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            if (vec_req) begin
              r_err <= 1'b1;
            end
          end
        end
        VEC_ADDR: begin
          r_state <= VEC_WAIT;
          r_cnt   <= 4'(MEM_LAT - 1);
        end
        VEC_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= VEC_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        VEC_DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_out   = r_addr;
  assign addr_valid = r_valid;
  assign vec_busy   = r_busy;
  // Pulses are masked while stalled and reappear once the stall lifts
  assign vec_done   = r_done & ~w_stall;
  assign err        = r_err & ~w_stall;

endmodule

// File: doc/mem_addr_sel.md
MEM_ADDR_SEL -- requirements
Module: mem_addr_sel

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning address width in bits.
REQ-002 SHALL have parameter NCH, default 4, meaning number of data address channels (>=2).
REQ-003 SHALL have parameter VEC_BASE, default 253, meaning address of exception vector 0.
REQ-004 SHALL have parameter NVEC, default 3, meaning number of exception vectors (vector k at VEC_BASE+k).
REQ-005 SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles (1..15).
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-008 SHALL have port sel  input  SW=$clog2(NCH)  data channel select.
REQ-009 SHALL have port data_in  input  NCH*WIDTH  packed channels, channel i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port vec_req  input  1  request exception vector fetch.
REQ-011 SHALL have port vec_cause  input  2  vector index for vec_req.
REQ-012 SHALL have port addr_out  output  WIDTH  registered memory address.
REQ-013 SHALL have port addr_valid  output  1  addr_out holds a valid address.
REQ-014 SHALL have port vec_busy  output  1  vector sequence in progress.
REQ-015 SHALL have port vec_done  output  1  one-cycle pulse: vector data available at memory output.
REQ-016 SHALL have port err  output  1  one-cycle pulse: illegal sel or vec_cause.

Function
REQ-017 SHALL implement FSM states IDLE, VEC_ADDR, VEC_WAIT, VEC_DONE.
REQ-018 In IDLE with vec_req=0, SHALL register addr_out <= channel sel, addr_valid <= 1 (one-cycle latency sel->addr_out).
REQ-019 In IDLE with sel >= NCH, SHALL hold addr_out unchanged, keep addr_valid, and pulse err next cycle.
REQ-020 In IDLE with vec_req=1 and vec_cause < NVEC, SHALL go to VEC_ADDR, register addr_out <= VEC_BASE+vec_cause, assert vec_busy.
REQ-021 In IDLE with vec_req=1 and vec_cause >= NVEC, SHALL stay IDLE, pulse err, and update addr_out per REQ-018.
REQ-022 vec_req SHALL take priority over sel when both apply in the same cycle.
REQ-023 VEC_ADDR SHALL last one cycle then enter VEC_WAIT with a counter loaded to MEM_LAT-1.
REQ-024 VEC_WAIT SHALL decrement the counter each cycle and enter VEC_DONE when counter is 0.
REQ-025 VEC_DONE SHALL pulse vec_done for exactly one cycle, then return to IDLE.
REQ-026 addr_out SHALL remain at the vector address from VEC_ADDR through VEC_DONE.
REQ-027 vec_busy SHALL be 1 in VEC_ADDR, VEC_WAIT, VEC_DONE; 0 in IDLE.
REQ-028 vec_req and sel SHALL be ignored while vec_busy=1 (no queuing).
REQ-029 Vector address SHALL be computed at WIDTH bits, wrapping modulo 2^WIDTH.
REQ-030 Total vec_req-to-vec_done latency SHALL be MEM_LAT+2 cycles.

Reset
REQ-031 With rst_n=0 at a clock edge, SHALL set state=IDLE, addr_out=0, addr_valid=0, vec_busy=0, vec_done=0, err=0, counter=0.
REQ-032 Reset asserted mid-sequence SHALL abort it with no vec_done pulse.
REQ-033 First cycle after reset release SHALL behave as IDLE per REQ-018.

Configuration
REQ-034 Macro MEM_ADDR_SEL_STALL_EN defined SHALL add port stall (input, 1): while 1, all registers and FSM hold, err/vec_done forced 0 and pulse after stall released only if condition still holds.
REQ-035 Without MEM_ADDR_SEL_STALL_EN, SHALL have no stall port and behave as stall=0.

Verification
REQ-036 Reset, then sel=2, data_in ch2=0x0000_1000 -> addr_out=0x1000, addr_valid=1 one cycle later.
REQ-037 vec_req=1, vec_cause=1, MEM_LAT=1 -> addr_out=254 next cycle, vec_busy=1 three cycles, vec_done pulse at cycle 3.
REQ-038 vec_req=1, vec_cause=3 (NVEC=3) -> err pulse, state stays IDLE, addr_out follows sel.
REQ-039 NCH=3, sel=3 -> addr_out holds previous value, err pulse one cycle.
REQ-040 MEM_LAT=4, rst_n=0 during VEC_WAIT -> all outputs 0, no vec_done.
REQ-041 MEM_ADDR_SEL_STALL_EN, stall=1 for 2 cycles in VEC_WAIT -> vec_done delayed by 2 cycles, addr_out stable.
